// File: rtl/inst_loader_if.sv
// Loader bus: program byte stream in, instruction-RAM write port and load status out.
// The loader (slave) accepts the stream and drives the writes; the testbench or host is the master.
interface inst_loader_if #(
  parameter int IW = 16,
  parameter int DW = 9
);
  logic          Start;
  logic [IW-1:0] BaseAddr;
  logic [7:0]    InData;
  logic          InValid;
  logic          InReady;
  logic          WrEn;
  logic [IW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic [15:0]   WordCount;
  logic          Done;
  logic          Err;
  logic          CpuHold;

  modport master (
    output Start, BaseAddr, InData, InValid,
    input  InReady, WrEn, WrAddr, WrData, WordCount, Done, Err, CpuHold
  );

  modport slave (
    input  Start, BaseAddr, InData, InValid,
    output InReady, WrEn, WrAddr, WrData, WordCount, Done, Err, CpuHold
  );
endinterface

// File: rtl/inst_loader.sv
// Program loader: 16-bit length then 2-byte words into instruction RAM; the write is registered one cycle after the hi byte.
// Backpressure: InReady is a pure state decode (high in LEN_*/DAT_*), so InValid gaps simply stall the FSM.
module inst_loader #(
  parameter int IW = 16,
  parameter int DW = 9
) (
  input logic         CLK,
  input logic         reset,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [IW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  state_t        state, state_nxt;
  logic [15:0]   len_q;
  logic [7:0]    lo_q;
  logic [IW-1:0] base_q;
  logic [15:0]   word_cnt;
  logic [15:0]   cnt_inc;
  logic          err_q;
  logic          wr_vld;
  wr_t           wr_q;
  logic          in_rdy;
  logic          xfer;
  logic          start_ok;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    start_ok  = 1'b0;
    cnt_inc   = word_cnt + 16'd1;
    case (state)
      IDLE, DONE: begin
        start_ok = bus.Start;
        if (bus.Start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_rdy = 1'b1;
        if (bus.InValid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_rdy = 1'b1;
        if (bus.InValid)
          state_nxt = ({bus.InData, len_q[7:0]} == 16'd0) ? DONE : DAT_LO;
      end
      DAT_LO: begin
        in_rdy = 1'b1;
        if (bus.InValid) state_nxt = DAT_HI;
      end
      DAT_HI: begin
        in_rdy = 1'b1;
        if (bus.InValid) state_nxt = (cnt_inc == len_q) ? DONE : DAT_LO;
      end
      default: state_nxt = IDLE;
    endcase
    xfer = in_rdy & bus.InValid;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      lo_q     <= '0;
      base_q   <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
      wr_vld   <= 1'b0;
      wr_q     <= '0;
    end else begin
      state  <= state_nxt;
      wr_vld <= 1'b0;
      if (start_ok) begin
        base_q   <= bus.BaseAddr;
        word_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (xfer) begin
        case (state)
          LEN_LO: len_q[7:0]  <= bus.InData;
          LEN_HI: len_q[15:8] <= bus.InData;
          DAT_LO: lo_q        <= bus.InData;
          DAT_HI: begin
            // Address wraps modulo 2**IW; a malformed hi byte is still written, only flagged.
            wr_vld      <= 1'b1;
            wr_q.addr   <= base_q + IW'(word_cnt);
            wr_q.dat    <= DW'({bus.InData[0], lo_q});
            word_cnt    <= cnt_inc;
            if (|bus.InData[7:1]) err_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.InReady   = in_rdy;
  assign bus.WrEn      = wr_vld;
  assign bus.WrAddr    = wr_q.addr;
  assign bus.WrData    = wr_q.dat;
  assign bus.WordCount = word_cnt;
  assign bus.Done      = (state == DONE);
  assign bus.Err       = err_q;
  assign bus.CpuHold   = (state != DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed stimulus for inst_loader; expected writes are queued at issue time and a negedge monitor checks them.
module tb_inst_loader;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  inst_loader_if #(.IW(16), .DW(9)) bus ();

  inst_loader #(.IW(16), .DW(9)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [8:0] d);
    exp_t e;
    e.addr = a;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (bus.WrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write", bus.WrAddr, bus.WrData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.WrAddr), 32'(e.addr));
        chk("wr_data", 32'(bus.WrData), 32'(e.dat));
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] base);
    bus.Start    = 1'b1;
    bus.BaseAddr = base;
    cycle();
    bus.Start    = 1'b0;
  endtask

  // Holds the byte until the loader accepts it; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.InData  = b;
    bus.InValid = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.InReady !== 1'b1 && n < 20);
    if (bus.InReady !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got InReady=%b, expected 1 within 20 cycles", bus.InReady);
    end
    cycle();
    bus.InValid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.BaseAddr = '0;
    bus.InData   = '0;
    bus.InValid  = 1'b0;
    cycle();

    chk("rst_inready",   32'(bus.InReady),   32'd0);
    chk("rst_wren",      32'(bus.WrEn),      32'd0);
    chk("rst_done",      32'(bus.Done),      32'd0);
    chk("rst_err",       32'(bus.Err),       32'd0);
    chk("rst_cpuhold",   32'(bus.CpuHold),   32'd1);
    chk("rst_wordcount", 32'(bus.WordCount), 32'd0);
    reset = 1'b0;
    cycle();

    // Three words, continuous valid.
    push_exp(16'h0010, 9'h12A);
    push_exp(16'h0011, 9'h055);
    push_exp(16'h0012, 9'h1FF);
    pulse_start(16'h0010);
    chk("t1_inready", 32'(bus.InReady), 32'd1);
    chk("t1_hold",    32'(bus.CpuHold), 32'd1);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h2A); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h01);
    chk("t1_done",  32'(bus.Done),      32'd1);
    chk("t1_hold0", 32'(bus.CpuHold),   32'd0);
    chk("t1_count", 32'(bus.WordCount), 32'd3);
    chk("t1_err",   32'(bus.Err),       32'd0);
    cycle();

    // Empty program.
    pulse_start(16'h0020);
    chk("t2_done_low", 32'(bus.Done), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    chk("t2_done",  32'(bus.Done),      32'd1);
    chk("t2_count", 32'(bus.WordCount), 32'd0);
    cycle();

    // Wrap at top of address space with gapped valid.
    push_exp(16'hFFFF, 9'h1AB);
    push_exp(16'h0000, 9'h034);
    pulse_start(16'hFFFF);
    send_byte(8'h02); cycle();
    send_byte(8'h00); cycle();
    send_byte(8'hAB); cycle();
    send_byte(8'h01); cycle();
    send_byte(8'h34); cycle();
    send_byte(8'h00);
    chk("t3_done",  32'(bus.Done),      32'd1);
    chk("t3_count", 32'(bus.WordCount), 32'd2);
    chk("t3_err",   32'(bus.Err),       32'd0);
    cycle();

    // Malformed hi byte: written, flagged.
    push_exp(16'h0100, 9'h107);
    pulse_start(16'h0100);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'h03);
    chk("t4_err",  32'(bus.Err),  32'd1);
    chk("t4_done", 32'(bus.Done), 32'd1);
    cycle();
    pulse_start(16'h0200);
    chk("t4_err_clr",   32'(bus.Err),       32'd0);
    chk("t4_count_clr", 32'(bus.WordCount), 32'd0);
    chk("t4_done_clr",  32'(bus.Done),      32'd0);

    // Start pulses mid-load are ignored.
    push_exp(16'h0200, 9'h011);
    push_exp(16'h0201, 9'h122);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11);
    pulse_start(16'h0999);
    send_byte(8'h00);
    pulse_start(16'h0888);
    send_byte(8'h22); send_byte(8'h01);
    chk("t5_done",  32'(bus.Done),      32'd1);
    chk("t5_count", 32'(bus.WordCount), 32'd2);
    chk("t5_err",   32'(bus.Err),       32'd0);
    cycle();

    // Reset after the first word of two.
    push_exp(16'h0300, 9'h033);
    pulse_start(16'h0300);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h00);
    send_byte(8'h44);
    reset = 1'b1;
    cycle();
    chk("t6_inready", 32'(bus.InReady),   32'd0);
    chk("t6_wren",    32'(bus.WrEn),      32'd0);
    chk("t6_wraddr",  32'(bus.WrAddr),    32'd0);
    chk("t6_wrdata",  32'(bus.WrData),    32'd0);
    chk("t6_count",   32'(bus.WordCount), 32'd0);
    chk("t6_done",    32'(bus.Done),      32'd0);
    chk("t6_err",     32'(bus.Err),       32'd0);
    chk("t6_hold",    32'(bus.CpuHold),   32'd1);
    reset       = 1'b0;
    bus.InData  = 8'h01;
    bus.InValid = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t6_idle_inready", 32'(bus.InReady), 32'd0);
    bus.InValid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
